// File: rtl/cache_arb_pkg.sv
// Shared types and constants for the cache request arbiter and its benches.
package cache_arb_pkg;

  // Arbiter sequencing states
  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ISSUE,
    ARB_WAIT,
    ARB_DONE
  } arb_state_t;

  // Default watchdog limit, in WAIT cycles
  localparam int unsigned DEFAULT_TIMEOUT = 8;

  // cache_ctrl hit_or_miss encodings
  localparam int unsigned HOM_W    = 2;
  localparam logic [1:0]  HOM_HIT  = 2'd1;
  localparam logic [1:0]  HOM_MISS = 2'd2;

endpackage

// File: rtl/cache_req_arbiter_rr_picker.sv
// Round-robin picker: first set request bit searching upward from rr_ptr_i with wrap.
module rr_picker #(
  parameter int unsigned NREQ = 4
) (
  input  logic [NREQ-1:0]         req_i,
  input  logic [$clog2(NREQ)-1:0] rr_ptr_i,
  output logic [NREQ-1:0]         pick_o,
  output logic [$clog2(NREQ)-1:0] index_o
);

  localparam int unsigned IW = $clog2(NREQ);

  logic [IW:0] cand;
  logic        found;

  // Scan NREQ candidates starting at the pointer; keep the first hit
  always_comb begin
    index_o = '0;
    found   = 1'b0;
    cand    = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = {1'b0, rr_ptr_i} + (IW+1)'(k);
      if (cand >= (IW+1)'(NREQ)) begin
        cand = cand - (IW+1)'(NREQ);
      end
      if (!found && req_i[cand[IW-1:0]]) begin
        found   = 1'b1;
        index_o = cand[IW-1:0];
      end
    end
    pick_o = NREQ'(found) << index_o;
  end

endmodule

// File: rtl/cache_req_arbiter.sv
// Round-robin arbiter sharing one cache_ctrl among NREQ read requesters,
// with completion detection and a watchdog abort for stuck lookups.
module cache_req_arbiter
  import cache_arb_pkg::*;
#(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned AW      = 8,
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*AW-1:0] req_addr,
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    done,
  output logic               done_hit,
  output logic               done_err,
  output logic [AW-1:0]      ctrl_address,
  output logic               ctrl_read,
  output logic               ctrl_abort,
  input  logic               ctrl_read_cache,
  input  logic               ctrl_read_memory
);

  localparam int unsigned IW  = $clog2(NREQ);
  localparam int unsigned WDW = $clog2(TIMEOUT + 1);

  arb_state_t        state_q;
  logic [IW-1:0]     win_q;
  logic [IW-1:0]     rr_ptr_q;
  logic [IW-1:0]     rr_ptr_d;
  logic [WDW-1:0]    wd_cnt_q;
  logic [WDW-1:0]    wd_cnt_d;
  logic [NREQ-1:0]   gnt_q;
  logic [NREQ-1:0]   done_q;
  logic              done_hit_q;
  logic              done_err_q;
  logic [AW-1:0]     ctrl_address_q;
  logic              ctrl_read_q;
  logic              ctrl_abort_q;

  logic [NREQ-1:0]   pick_oh;
  logic [IW-1:0]     pick_idx;

  rr_picker #(
    .NREQ(NREQ)
  ) u_picker (
    .req_i   (req),
    .rr_ptr_i(rr_ptr_q),
    .pick_o  (pick_oh),
    .index_o (pick_idx)
  );

  // Pointer moves one past the last winner, wrapping at NREQ
  assign rr_ptr_d = (win_q == IW'(NREQ - 1)) ? '0 : win_q + 1'b1;

  // Watchdog counter saturates so it can never wrap back under the limit
  assign wd_cnt_d = (wd_cnt_q == WDW'(TIMEOUT)) ? wd_cnt_q : wd_cnt_q + 1'b1;

  // Arbitration / sequencing FSM with registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ARB_IDLE;
      win_q          <= '0;
      rr_ptr_q       <= '0;
      wd_cnt_q       <= '0;
      gnt_q          <= '0;
      done_q         <= '0;
      done_hit_q     <= 1'b0;
      done_err_q     <= 1'b0;
      ctrl_address_q <= '0;
      ctrl_read_q    <= 1'b0;
      ctrl_abort_q   <= 1'b0;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (|req) begin
            win_q          <= pick_idx;
            gnt_q          <= pick_oh;
            ctrl_address_q <= req_addr[pick_idx*AW +: AW];
            ctrl_read_q    <= 1'b1;
            state_q        <= ARB_ISSUE;
          end
        end
        ARB_ISSUE: begin
          ctrl_read_q <= 1'b0;
          wd_cnt_q    <= '0;
          state_q     <= ARB_WAIT;
        end
        ARB_WAIT: begin
          wd_cnt_q <= wd_cnt_d;
          if (ctrl_read_cache) begin
            done_hit_q <= 1'b1;
            done_q     <= gnt_q;
            state_q    <= ARB_DONE;
          end else if (ctrl_read_memory) begin
            done_hit_q <= 1'b0;
            done_q     <= gnt_q;
            state_q    <= ARB_DONE;
          end else if (wd_cnt_q == WDW'(TIMEOUT - 1)) begin
            done_err_q   <= 1'b1;
            ctrl_abort_q <= 1'b1;
            done_q       <= gnt_q;
            state_q      <= ARB_DONE;
          end
        end
        ARB_DONE: begin
          done_q       <= '0;
          done_hit_q   <= 1'b0;
          done_err_q   <= 1'b0;
          ctrl_abort_q <= 1'b0;
          gnt_q        <= '0;
          rr_ptr_q     <= rr_ptr_d;
          state_q      <= ARB_IDLE;
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  assign gnt          = gnt_q;
  assign done         = done_q;
  assign done_hit     = done_hit_q;
  assign done_err     = done_err_q;
  assign ctrl_address = ctrl_address_q;
  assign ctrl_read    = ctrl_read_q;
  assign ctrl_abort   = ctrl_abort_q;

endmodule

// File: tb/tb_cache_req_arbiter.sv
// Self-checking bench for cache_req_arbiter: directed scenarios plus random
// transactions against a transaction-level round-robin model.
module tb_cache_req_arbiter;
  import cache_arb_pkg::*;

  localparam int unsigned NREQ    = 4;
  localparam int unsigned AW      = 8;
  localparam int unsigned TIMEOUT = DEFAULT_TIMEOUT;
  localparam int KIND_NONE = 0;   // cache_ctrl never answers (hit_or_miss held 0)
  localparam int KIND_BOTH = 3;   // read_cache and read_memory together

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [NREQ-1:0]    req = '0;
  logic [NREQ*AW-1:0] req_addr = '0;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    done;
  logic               done_hit;
  logic               done_err;
  logic [AW-1:0]      ctrl_address;
  logic               ctrl_read;
  logic               ctrl_abort;
  logic               ctrl_read_cache = 1'b0;
  logic               ctrl_read_memory = 1'b0;

  int checks    = 0;
  int failures  = 0;
  int model_ptr = 0;

  always #5 clk = ~clk;

  cache_req_arbiter #(
    .NREQ(NREQ), .AW(AW), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .req             (req),
    .req_addr        (req_addr),
    .gnt             (gnt),
    .done            (done),
    .done_hit        (done_hit),
    .done_err        (done_err),
    .ctrl_address    (ctrl_address),
    .ctrl_read       (ctrl_read),
    .ctrl_abort      (ctrl_abort),
    .ctrl_read_cache (ctrl_read_cache),
    .ctrl_read_memory(ctrl_read_memory)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Round-robin rule: first requesting index at or after ptr, wrapping
  function automatic int exp_winner(input logic [NREQ-1:0] r, input int ptr);
    for (int k = 0; k < int'(NREQ); k++) begin
      if (r[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    end
    return 0;
  endfunction

  function automatic logic [NREQ-1:0] rand_req();
    return NREQ'($urandom);
  endfunction

  function automatic logic [NREQ*AW-1:0] rand_addr();
    return (NREQ*AW)'($urandom);
  endfunction

  // One complete transaction, entered and left at a negedge in IDLE
  task automatic run_txn(input logic [NREQ-1:0] r, input logic [NREQ*AW-1:0] a,
                         input int kind, input int d, input bit drop);
    int              w;
    int              n;
    bit              seen;
    logic [AW-1:0]   ea;
    logic [NREQ-1:0] wmask;
    w     = exp_winner(r, model_ptr);
    wmask = NREQ'(1) << w;
    ea    = a[w*AW +: AW];
    req      = r;
    req_addr = a;
    @(negedge clk);
    chk("issue_read", 32'(ctrl_read), 32'd1);
    chk("issue_gnt", 32'(gnt), 32'(wmask));
    chk("issue_addr", 32'(ctrl_address), 32'(ea));
    chk("issue_done", 32'(done), 32'd0);
    if (kind == KIND_NONE) ctrl_read_cache = 1'b1;  // outside WAIT, must be ignored
    req      = drop ? (rand_req() & ~wmask) : (rand_req() | wmask);
    req_addr = rand_addr();
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 4 * int'(TIMEOUT)) begin
      @(negedge clk);
      n++;
      ctrl_read_cache  = 1'b0;
      ctrl_read_memory = 1'b0;
      if (done != '0) begin
        seen = 1'b1;
      end else begin
        if (n == 1) chk("read_one_cycle", 32'(ctrl_read), 32'd0);
        chk("wait_hold", 32'({ctrl_abort, gnt, ctrl_address}), 32'({1'b0, wmask, ea}));
        if (kind != KIND_NONE && n == d + 1) begin
          ctrl_read_cache  = (kind == int'(HOM_HIT))  || (kind == KIND_BOTH);
          ctrl_read_memory = (kind == int'(HOM_MISS)) || (kind == KIND_BOTH);
        end
      end
    end
    chk("done_seen", 32'(seen), 32'd1);
    if (seen) begin
      chk("done_latency", 32'(n), (kind == KIND_NONE) ? 32'(TIMEOUT + 1) : 32'(d + 2));
      chk("done_vec", 32'(done), 32'(wmask));
      chk("done_hit", 32'(done_hit), 32'((kind == int'(HOM_HIT)) || (kind == KIND_BOTH)));
      chk("done_err", 32'(done_err), 32'(kind == KIND_NONE));
      chk("ctrl_abort", 32'(ctrl_abort), 32'(kind == KIND_NONE));
      chk("done_gnt", 32'(gnt), 32'(wmask));
    end
    model_ptr = (w + 1) % NREQ;
    req = '0;
    @(negedge clk);
    chk("idle_outs", 32'({gnt, done, ctrl_read, ctrl_abort, done_err, done_hit}), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    ctrl_read_cache  = 1'b0;
    ctrl_read_memory = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_ptr = 0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench time limit reached");
  end

  initial begin
    logic [NREQ-1:0] r;
    @(negedge clk);
    chk("reset_outs", 32'({gnt, done, done_hit, done_err, ctrl_address, ctrl_read, ctrl_abort}), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_idle", 32'({gnt, ctrl_read}), 32'd0);

    // Single hit and single miss
    run_txn(4'b0001, 32'h0000_003C, int'(HOM_HIT), 2, 1'b0);
    run_txn(4'b0100, 32'h00A5_0000, int'(HOM_MISS), 2, 1'b0);

    // Round robin from pointer 0: expect 0,1,2,3,0
    do_reset();
    repeat (5) run_txn(4'b1111, 32'hD4C3_B2A1, int'(HOM_HIT), 2, 1'b0);

    // Watchdog abort on requester 1, then a normal grant
    run_txn(4'b0010, 32'h1122_3344, KIND_NONE, 0, 1'b0);
    run_txn(4'b0110, 32'h9988_7766, int'(HOM_HIT), 1, 1'b0);

    // Reset three cycles after ctrl_read, pointer nonzero beforehand
    req      = 4'b0100;
    req_addr = 32'h5566_7788;
    @(negedge clk);
    chk("rst_issue_gnt", 32'(gnt), 32'h4);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1 chk("rst_async_outs",
           32'({gnt, done, done_hit, done_err, ctrl_address, ctrl_read, ctrl_abort}), 32'd0);
    req = '0;
    repeat (2) begin
      @(negedge clk);
      chk("rst_no_done", 32'(done), 32'd0);
    end
    rst = 1'b0;
    model_ptr = 0;
    @(negedge clk);
    run_txn(4'b1010, 32'hCAFE_F00D, int'(HOM_MISS), 0, 1'b0);

    // Winner drops req in WAIT; cache and memory respond together
    run_txn(4'b1001, 32'h0F1E_2D3C, KIND_BOTH, 3, 1'b1);

    // Random traffic
    for (int t = 0; t < 40; t++) begin
      r = rand_req();
      if (r == '0) r = 4'b0001;
      run_txn(r, rand_addr(), int'($urandom_range(0, 3)),
              int'($urandom_range(0, TIMEOUT - 1)), bit'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
